// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words from instruction memory over a
// req/ack handshake and queues {inst, pc} pairs for decode, with redirect/flush support.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic [6:0]  opcode_o
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_r;
   logic [31:0]   fetch_pc_r;
   logic [31:0]   req_addr_r;
   logic [31:0]   inst_q_r [QDEPTH];
   logic [31:0]   pc_q_r   [QDEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;

   logic          push_s;
   logic          pop_s;
   logic          has_room_s;
   logic [CW-1:0] count_next_s;
   logic [31:0]   redir_pc_s;
   logic [31:0]   pc_plus4_s;
   logic [31:0]   head_inst_s;
   logic [31:0]   head_pc_s;

   // A redirect squashes both the same-cycle push and pop; the queue is flushed instead.
   assign push_s       = (state_r == REQ) && imem_ack_i && !redirect_i;
   assign pop_s        = (count_r != {CW{1'b0}}) && inst_ready_i && !redirect_i;
   assign count_next_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
   assign has_room_s   = (count_next_s < QFULL);
   assign redir_pc_s   = redirect_pc_i & 32'hFFFF_FFFC;
   assign pc_plus4_s   = fetch_pc_r + 32'd4;

   // Queue head presentation, forced to zero while the queue is empty.
   always_comb begin
      head_inst_s = 32'h0000_0000;
      head_pc_s   = 32'h0000_0000;
      if (count_r != {CW{1'b0}}) begin
         head_inst_s = inst_q_r[rd_ptr_r];
         head_pc_s   = pc_q_r[rd_ptr_r];
      end else begin
         head_inst_s = 32'h0000_0000;
         head_pc_s   = 32'h0000_0000;
      end
   end

   assign inst_valid_o = (count_r != {CW{1'b0}});
   assign inst_o       = head_inst_s;
   assign pc_o         = head_pc_s;
   assign opcode_o     = head_inst_s[6:0];
   assign imem_req_o   = (state_r == REQ) || (state_r == DROP);
   assign imem_addr_o  = req_addr_r;

   // Instruction queue storage, pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < QDEPTH; i++) begin
            inst_q_r[i] <= 32'h0000_0000;
            pc_q_r[i]   <= 32'h0000_0000;
         end
      end else if (redirect_i) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            inst_q_r[wr_ptr_r] <= imem_data_i;
            pc_q_r[wr_ptr_r]   <= req_addr_r;
            wr_ptr_r           <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r <= count_next_s;
      end
   end

   // Fetch FSM: PC, request address and the stale-response drop state.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r    <= IDLE;
         fetch_pc_r <= RESET_PC;
         req_addr_r <= 32'h0000_0000;
      end else if (redirect_i) begin
         fetch_pc_r <= redir_pc_s;
         case (state_r)
            REQ, DROP: begin
               if (!imem_ack_i) begin
                  // Old request must still be completed; its data is discarded.
                  state_r <= DROP;
               end else if (start_i) begin
                  state_r    <= REQ;
                  req_addr_r <= redir_pc_s;
               end else begin
                  state_r <= IDLE;
               end
            end
            default: begin
               if (start_i) begin
                  state_r    <= REQ;
                  req_addr_r <= redir_pc_s;
               end else begin
                  state_r <= IDLE;
               end
            end
         endcase
      end else begin
         case (state_r)
            IDLE: begin
               if (start_i && (count_r < QFULL)) begin
                  state_r    <= REQ;
                  req_addr_r <= fetch_pc_r;
               end else begin
                  state_r <= IDLE;
               end
            end
            REQ: begin
               if (imem_ack_i) begin
                  fetch_pc_r <= pc_plus4_s;
                  if (start_i && has_room_s) begin
                     state_r    <= REQ;
                     req_addr_r <= pc_plus4_s;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= REQ;
               end
            end
            DROP: begin
               if (imem_ack_i) begin
                  if (start_i && has_room_s) begin
                     state_r    <= REQ;
                     req_addr_r <= fetch_pc_r;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= DROP;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, streaming, backpressure, wait states,
// redirect with a stale in-flight response, redirect+ack+pop, and reset mid-request.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [6:0]  opcode_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic auto_mem = 1'b0;

   inst_fetch_unit #(
      .RESET_PC(32'h0000_0000),
      .QDEPTH  (2)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_data_i  (imem_data_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .pc_o         (pc_o),
      .opcode_o     (opcode_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one cycle; in auto mode memory answers every request immediately with data=addr.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (auto_mem) begin
         imem_ack_i  = imem_req_o;
         imem_data_i = imem_addr_o;
      end
   endtask

   task automatic do_reset();
      rst_i      = 1'b0;
      start_i    = 1'b0;
      redirect_i = 1'b0;
      imem_ack_i = 1'b0;
      auto_mem   = 1'b0;
      cyc();
      cyc();
      rst_i = 1'b1;
   endtask

   initial begin
      logic [31:0] exp_pc;
      rst_i         = 1'b0;
      start_i       = 1'b0;
      imem_ack_i    = 1'b0;
      imem_data_i   = 32'h0000_0000;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0000_0000;
      inst_ready_i  = 1'b0;

      // Reset state
      repeat (3) cyc();
      check("rst_req",    {31'd0, imem_req_o},   32'd0);
      check("rst_addr",   imem_addr_o,           32'd0);
      check("rst_valid",  {31'd0, inst_valid_o}, 32'd0);
      check("rst_inst",   inst_o,                32'd0);
      check("rst_pc",     pc_o,                  32'd0);
      check("rst_opcode", {25'd0, opcode_o},     32'd0);

      // Release with start, zero-wait memory, streaming
      rst_i        = 1'b1;
      start_i      = 1'b1;
      inst_ready_i = 1'b1;
      auto_mem     = 1'b1;
      cyc();
      check("c1_req",  {31'd0, imem_req_o}, 32'd1);
      check("c1_addr", imem_addr_o,         32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         exp_pc = 32'(i) * 32'd4;
         check("stream_valid",  {31'd0, inst_valid_o}, 32'd1);
         check("stream_pc",     pc_o,                  exp_pc);
         check("stream_inst",   inst_o,                exp_pc);
         check("stream_opcode", {25'd0, opcode_o},     {25'd0, exp_pc[6:0]});
      end

      // Backpressure with a 2-entry queue
      do_reset();
      start_i      = 1'b1;
      inst_ready_i = 1'b0;
      auto_mem     = 1'b1;
      cyc();
      cyc();
      cyc();
      check("bp_req_drop", {31'd0, imem_req_o},   32'd0);
      check("bp_valid",    {31'd0, inst_valid_o}, 32'd1);
      check("bp_head0",    pc_o,                  32'd0);
      cyc();
      check("bp_hold_req", {31'd0, imem_req_o},   32'd0);
      check("bp_hold_pc",  pc_o,                  32'd0);
      inst_ready_i = 1'b1;
      cyc();
      inst_ready_i = 1'b0;
      check("bp_head1",    pc_o,                  32'd4);
      check("bp_no_req",   {31'd0, imem_req_o},   32'd0);
      cyc();
      check("bp_req8",     {31'd0, imem_req_o},   32'd1);
      check("bp_addr8",    imem_addr_o,           32'd8);

      // Wait states: ack three cycles after the request
      do_reset();
      start_i      = 1'b1;
      inst_ready_i = 1'b1;
      imem_ack_i   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("ws_req",   {31'd0, imem_req_o},   32'd1);
         check("ws_addr",  imem_addr_o,           32'd0);
         check("ws_valid", {31'd0, inst_valid_o}, 32'd0);
         if (i == 3) begin
            imem_ack_i  = 1'b1;
            imem_data_i = 32'hDEAD_0013;
         end
      end
      cyc();
      imem_ack_i = 1'b0;
      check("ws_valid1", {31'd0, inst_valid_o}, 32'd1);
      check("ws_inst",   inst_o,                32'hDEAD_0013);
      check("ws_opcode", {25'd0, opcode_o},     32'h0000_0013);
      check("ws_next",   imem_addr_o,           32'd4);
      cyc();
      check("ws_no_dup", {31'd0, inst_valid_o}, 32'd0);

      // Redirect while waiting on address 8
      do_reset();
      start_i      = 1'b1;
      inst_ready_i = 1'b1;
      auto_mem     = 1'b1;
      cyc();
      cyc();
      cyc();
      check("rd_addr8", imem_addr_o, 32'd8);
      auto_mem      = 1'b0;
      imem_ack_i    = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      cyc();
      redirect_i = 1'b0;
      check("rd_flush",     {31'd0, inst_valid_o}, 32'd0);
      check("rd_drop_req",  {31'd0, imem_req_o},   32'd1);
      check("rd_drop_addr", imem_addr_o,           32'd8);
      cyc();
      check("rd_hold_addr", imem_addr_o, 32'd8);
      imem_ack_i  = 1'b1;
      imem_data_i = 32'h0000_0BAD;
      cyc();
      imem_ack_i = 1'b0;
      check("rd_stale",   {31'd0, inst_valid_o}, 32'd0);
      check("rd_new_req", {31'd0, imem_req_o},   32'd1);
      check("rd_new_pc",  imem_addr_o,           32'h0000_0100);
      imem_ack_i  = 1'b1;
      imem_data_i = 32'h0000_0100;
      cyc();
      imem_ack_i = 1'b0;
      check("rd_valid", {31'd0, inst_valid_o}, 32'd1);
      check("rd_pc",    pc_o,                  32'h0000_0100);

      // Redirect + ack + pop in the same cycle, then reset mid-request
      do_reset();
      start_i      = 1'b1;
      inst_ready_i = 1'b1;
      auto_mem     = 1'b1;
      cyc();
      cyc();
      check("rap_head", pc_o, 32'd0);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      cyc();
      redirect_i = 1'b0;
      check("rap_valid", {31'd0, inst_valid_o}, 32'd0);
      check("rap_req",   {31'd0, imem_req_o},   32'd1);
      check("rap_addr",  imem_addr_o,           32'h0000_0200);
      cyc();
      check("rap_pc", pc_o, 32'h0000_0200);
      auto_mem   = 1'b0;
      imem_ack_i = 1'b0;
      cyc();
      check("mr_addr", imem_addr_o, 32'h0000_0204);
      rst_i = 1'b0;
      cyc();
      check("mr_req",  {31'd0, imem_req_o},   32'd0);
      check("mr_addr0", imem_addr_o,          32'd0);
      check("mr_valid", {31'd0, inst_valid_o}, 32'd0);
      rst_i      = 1'b1;
      start_i    = 1'b0;
      imem_ack_i = 1'b1;
      cyc();
      imem_ack_i = 1'b0;
      check("late_ack_req",   {31'd0, imem_req_o},   32'd0);
      check("late_ack_valid", {31'd0, inst_valid_o}, 32'd0);
      start_i = 1'b1;
      cyc();
      check("mr_restart_req",  {31'd0, imem_req_o}, 32'd1);
      check("mr_restart_addr", imem_addr_o,         32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage of the single-cycle RISC-V core. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions in a small queue. Presents instruction, PC and opcode to the decode/Control stage with a valid/ready handshake. Supports redirect (branch/jump) with flush and discard of a stale in-flight response.

## Interface
- RESET_PC, 32'h0000_0000 — fetch PC after reset
- QDEPTH, 2 — instruction queue entries; power of 2, ≥2
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-low reset
- start_i  in  1  fetch enable; low = issue no new requests; an outstanding request still completes
- imem_req_o  out  1  memory request
- imem_addr_o  out  32  word-aligned request address
- imem_ack_i  in  1  response strobe; imem_data_i valid in the same cycle
- imem_data_i  in  32  instruction word
- redirect_i  in  1  one-cycle redirect pulse
- redirect_pc_i  in  32  new PC; bits [1:0] forced to 0
- inst_valid_o  out  1  queue head valid
- inst_ready_i  in  1  consumer accepts head
- inst_o  out  32  head instruction; 0 when empty
- pc_o  out  32  head PC; 0 when empty
- opcode_o  out  7  inst_o[6:0], feeds Control

## Operation
- State: fetch_pc (32b), FSM {IDLE, REQ, DROP}, queue of {inst, pc} with count 0..QDEPTH.
- imem_req_o = (state==REQ || state==DROP). imem_addr_o = registered request address, held stable until the acknowledging cycle.
- IDLE → REQ when start_i && count<QDEPTH. Request address = fetch_pc.
- REQ with imem_ack_i: push {imem_data_i, req address}; fetch_pc += 4 (wraps mod 2^32). Next state: REQ at fetch_pc+4 if start_i and post-push/pop count<QDEPTH, else IDLE. Count space is checked at issue, so a push never overflows.
- Pop when inst_valid_o && inst_ready_i. Push and pop in the same cycle leave count unchanged.
- Redirect has priority over everything:
  - Queue is flushed; the same-cycle pop and push are ignored. fetch_pc = {redirect_pc_i[31:2],2'b00}.
  - From IDLE, or from REQ/DROP with imem_ack_i the same cycle: go to REQ at the new PC if start_i, else IDLE. The acked data is discarded.
  - From REQ/DROP without ack: go to DROP. Keep the old address and request asserted until ack, then discard the data.
  - DROP with ack: go to REQ at fetch_pc if start_i, else IDLE.
  - A second redirect during DROP updates fetch_pc; state stays DROP.
- Reset values: state IDLE, fetch_pc=RESET_PC, count 0, imem_req_o 0, imem_addr_o 0, inst_valid_o 0, inst_o 0, pc_o 0, opcode_o 0.
- Reset mid-transaction abandons the request. A late ack after reset is ignored because state is IDLE.

## Timing
- All outputs are registered or derived from registered state; imem_ack_i has no combinational path to outputs.
- start_i high at cycle t (IDLE, empty): imem_req_o at t+1.
- Zero-wait memory (ack in the first request cycle): inst_valid_o at t+2. Sustained throughput is 1 instruction/cycle with inst_ready_i=1.
- N wait cycles add N cycles of latency. The address stays constant throughout.
- Redirect at t: inst_valid_o=0 at t+1.
  - No pending request: request to the new PC at t+1; valid at t+2 with zero-wait memory.
  - With a pending request: the new request issues the cycle after the stale ack.
- Full queue with inst_ready_i=0: no request issues. The cycle after a pop, the FSM may re-enter REQ.

## Test plan
- Reset check: hold rst_i=0 for 3 cycles → all outputs 0. Release with start_i=1, zero-wait memory → imem_addr_o=0 at cycle 1, inst_valid_o=1 with pc_o=0 at cycle 2.
- Streaming: zero-wait memory returning data=addr, inst_ready_i=1 → pc_o 0,4,8,12 on consecutive cycles; inst_o equals pc_o; opcode_o=inst_o[6:0].
- Backpressure: inst_ready_i=0, QDEPTH=2 → count reaches 2 (pc 0,4 held) and imem_req_o drops. Raise ready for 1 cycle → pc 0 pops, then the request for addr 8 issues.
- Wait states: ack 3 cycles after req → imem_addr_o stable across all 4 cycles; no duplicate push.
- Redirect with in-flight request: redirect to 0x103 while waiting on addr 8 → queue empties next cycle and state is DROP. Stale ack data is not pushed. Next request address is 0x100, and the first valid pc_o=0x100.
- Simultaneous redirect+ack+pop: redirect to 0x200 → acked data discarded, no pop, next request 0x200 the following cycle. A reset pulse mid-request returns to IDLE, and the next request address is RESET_PC.
